// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int unsigned IFQ_DEFAULT_DEPTH = 4;
  localparam int unsigned IFQ_INST_W        = 32;

  localparam logic [IFQ_INST_W-1:0] NOP_INST   = 32'h0;
  localparam logic                  RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'b00,
    IFQ_WAIT = 2'b01,
    IFQ_DROP = 2'b10
  } ifq_state_e;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Ring buffer of fetched {pc, inst} pairs; clear wins over push/pop.
module ifq_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEFAULT_DEPTH,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// IF stage: one ROM read per PC, DEPTH-entry queue, registered IF/ID output.
// Optional performance counters enabled by defining IFQ_PERF_CNT_EN.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEFAULT_DEPTH,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          pc_en,
  input  logic [5:0]    stall,
  input  logic          flush,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ack,
  input  logic [DW-1:0] rom_data,
  output logic          stallreq_if,
  output logic [AW-1:0] id_pc,
  output logic [DW-1:0] id_inst,
`ifdef IFQ_PERF_CNT_EN
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt,
`endif
  output logic          id_valid
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  ifq_state_e        state_q, state_d;
  logic              rom_req_q, rom_req_d;
  logic [AW-1:0]     rom_addr_q, rom_addr_d;
  logic [AW-1:0]     id_pc_q, id_pc_d;
  logic [DW-1:0]     id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [AW+DW-1:0]  fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              unused_c;

  ifq_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata ({rom_addr_q, rom_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ROM request FSM; DROP swallows the ack of a request orphaned by flush.
  always_comb begin
    state_d    = state_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    push       = 1'b0;
    unique case (state_q)
      IFQ_IDLE: begin
        if (pc_en && !flush && !fifo_full) begin
          rom_addr_d = pc;
          rom_req_d  = 1'b1;
          state_d    = IFQ_WAIT;
        end
      end
      IFQ_WAIT: begin
        if (rom_ack) begin
          push      = !flush;
          rom_req_d = 1'b0;
          state_d   = IFQ_IDLE;
        end else if (flush) begin
          state_d = IFQ_DROP;
        end
      end
      IFQ_DROP: begin
        if (rom_ack) begin
          rom_req_d = 1'b0;
          state_d   = IFQ_IDLE;
        end
      end
      default: begin
        rom_req_d = 1'b0;
        state_d   = IFQ_IDLE;
      end
    endcase
  end

  // IF/ID register: flush beats stall[1], which beats a pop.
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    pop        = 1'b0;
    if (flush) begin
      id_pc_d    = '0;
      id_inst_d  = DW'(NOP_INST);
      id_valid_d = 1'b0;
    end else if (!stall[1]) begin
      if (!fifo_empty) begin
        {id_pc_d, id_inst_d} = fifo_rdata;
        id_valid_d           = 1'b1;
        pop                  = 1'b1;
      end else begin
        id_pc_d    = '0;
        id_inst_d  = DW'(NOP_INST);
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q    <= IFQ_IDLE;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  // pc_reg may advance only in the cycle its address lands in the queue.
  assign stallreq_if = pc_en && !((state_q == IFQ_WAIT) && rom_ack && !flush);

  assign rom_req  = rom_req_q;
  assign rom_addr = rom_addr_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign unused_c = ^{stall[5:2], stall[0], fifo_count};

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q + 32'(stallreq_if);
    perf_flush_cnt_d = perf_flush_cnt_q + 32'(flush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: per-cycle vector table plus reset/perf sequences.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic [5:0]  stall;
  logic        flush;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  inst_fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_en       (pc_en),
    .stall       (stall),
    .flush       (flush),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .stallreq_if (stallreq_if),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
`ifdef IFQ_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .id_valid    (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] data;
    logic        st1;
    logic        fl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_sr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        cpc;
  } vec_t;

  localparam int NV = 43;
  vec_t tv [NV];

  function automatic logic [31:0] d(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic vec_t mk(input logic en, input logic [31:0] p, input logic ack,
                              input logic [31:0] data, input logic st1, input logic fl,
                              input logic e_req, input logic [31:0] e_addr, input logic e_sr,
                              input logic e_val, input logic [31:0] e_pc,
                              input logic [31:0] e_inst, input logic cpc);
    vec_t v;
    v.en = en; v.pc = p; v.ack = ack; v.data = data; v.st1 = st1; v.fl = fl;
    v.e_req = e_req; v.e_addr = e_addr; v.e_sr = e_sr; v.e_val = e_val;
    v.e_pc = e_pc; v.e_inst = e_inst; v.cpc = cpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] p, input logic ack,
                       input logic [31:0] data, input logic st1, input logic fl);
    pc_en    = en;
    pc       = p;
    rom_ack  = ack;
    rom_data = data;
    stall    = {4'b0, st1, 1'b0};
    flush    = fl;
  endtask

  initial begin
    // Normal stream pc=0,4,8 (ROM acks in the first WAIT cycle)
    tv[0]  = mk(1, 32'h0,   0, 0,         0, 0,  0, 32'h0,   1, 0, 0,       0,          0);
    tv[1]  = mk(1, 32'h0,   1, d(32'h0),  0, 0,  1, 32'h0,   0, 0, 0,       0,          0);
    tv[2]  = mk(1, 32'h4,   0, 0,         0, 0,  0, 32'h0,   1, 0, 0,       0,          0);
    tv[3]  = mk(1, 32'h4,   1, d(32'h4),  0, 0,  1, 32'h4,   0, 1, 32'h0,   d(32'h0),   1);
    tv[4]  = mk(1, 32'h8,   0, 0,         0, 0,  0, 32'h4,   1, 0, 0,       0,          0);
    tv[5]  = mk(1, 32'h8,   1, d(32'h8),  0, 0,  1, 32'h8,   0, 1, 32'h4,   d(32'h4),   1);
    tv[6]  = mk(0, 32'hC,   0, 0,         0, 0,  0, 32'h8,   0, 0, 0,       0,          0);
    tv[7]  = mk(0, 32'hC,   0, 0,         0, 0,  0, 32'h8,   0, 1, 32'h8,   d(32'h8),   1);
    tv[8]  = mk(0, 32'hC,   0, 0,         0, 0,  0, 32'h8,   0, 0, 0,       0,          0);
    // ID held by stall[1]: queue fills to 4, then no issue while full
    tv[9]  = mk(1, 32'h0,   0, 0,         1, 0,  0, 32'h8,   1, 0, 0,       0,          0);
    tv[10] = mk(1, 32'h0,   1, d(32'h0),  1, 0,  1, 32'h0,   0, 0, 0,       0,          0);
    tv[11] = mk(1, 32'h4,   0, 0,         1, 0,  0, 32'h0,   1, 0, 0,       0,          0);
    tv[12] = mk(1, 32'h4,   1, d(32'h4),  1, 0,  1, 32'h4,   0, 0, 0,       0,          0);
    tv[13] = mk(1, 32'h8,   0, 0,         1, 0,  0, 32'h4,   1, 0, 0,       0,          0);
    tv[14] = mk(1, 32'h8,   1, d(32'h8),  1, 0,  1, 32'h8,   0, 0, 0,       0,          0);
    tv[15] = mk(1, 32'hC,   0, 0,         1, 0,  0, 32'h8,   1, 0, 0,       0,          0);
    tv[16] = mk(1, 32'hC,   1, d(32'hC),  1, 0,  1, 32'hC,   0, 0, 0,       0,          0);
    tv[17] = mk(1, 32'h10,  0, 0,         1, 0,  0, 32'hC,   1, 0, 0,       0,          0);
    tv[18] = mk(1, 32'h10,  0, 0,         1, 0,  0, 32'hC,   1, 0, 0,       0,          0);
    tv[19] = mk(1, 32'h10,  0, 0,         0, 0,  0, 32'hC,   1, 0, 0,       0,          0);
    tv[20] = mk(1, 32'h10,  0, 0,         0, 0,  0, 32'hC,   1, 1, 32'h0,   d(32'h0),   1);
    tv[21] = mk(1, 32'h10,  1, d(32'h10), 0, 0,  1, 32'h10,  0, 1, 32'h4,   d(32'h4),   1);
    tv[22] = mk(0, 32'h14,  0, 0,         0, 0,  0, 32'h10,  0, 1, 32'h8,   d(32'h8),   1);
    tv[23] = mk(0, 32'h14,  0, 0,         0, 0,  0, 32'h10,  0, 1, 32'hC,   d(32'hC),   1);
    tv[24] = mk(0, 32'h14,  0, 0,         0, 0,  0, 32'h10,  0, 1, 32'h10,  d(32'h10),  1);
    tv[25] = mk(0, 32'h14,  0, 0,         0, 0,  0, 32'h10,  0, 0, 0,       0,          0);
    // Flush during WAIT, ack three cycles later is discarded, then fetch new pc
    tv[26] = mk(1, 32'h20,  0, 0,         0, 0,  0, 32'h10,  1, 0, 0,       0,          0);
    tv[27] = mk(1, 32'h20,  0, 0,         0, 1,  1, 32'h20,  1, 0, 0,       0,          0);
    tv[28] = mk(1, 32'h100, 0, 0,         0, 0,  1, 32'h20,  1, 0, 0,       0,          0);
    tv[29] = mk(1, 32'h100, 0, 0,         0, 0,  1, 32'h20,  1, 0, 0,       0,          0);
    tv[30] = mk(1, 32'h100, 1, 32'hDEADBEEF, 0, 0, 1, 32'h20, 1, 0, 0,      0,          0);
    tv[31] = mk(1, 32'h100, 0, 0,         0, 0,  0, 32'h20,  1, 0, 0,       0,          0);
    tv[32] = mk(1, 32'h100, 1, d(32'h100),0, 0,  1, 32'h100, 0, 0, 0,       0,          0);
    tv[33] = mk(0, 32'h104, 0, 0,         0, 0,  0, 32'h100, 0, 0, 0,       0,          0);
    tv[34] = mk(0, 32'h104, 0, 0,         0, 0,  0, 32'h100, 0, 1, 32'h100, d(32'h100), 1);
    // Flush coincides with rom_ack and a pop of a nonempty queue
    tv[35] = mk(1, 32'h40,  0, 0,         1, 0,  0, 32'h100, 1, 0, 0,       0,          0);
    tv[36] = mk(1, 32'h40,  1, d(32'h40), 1, 0,  1, 32'h40,  0, 0, 0,       0,          0);
    tv[37] = mk(1, 32'h44,  0, 0,         1, 0,  0, 32'h40,  1, 0, 0,       0,          0);
    tv[38] = mk(1, 32'h44,  1, d(32'h44), 1, 0,  1, 32'h44,  0, 0, 0,       0,          0);
    tv[39] = mk(1, 32'h48,  0, 0,         0, 0,  0, 32'h44,  1, 0, 0,       0,          0);
    tv[40] = mk(1, 32'h48,  1, d(32'h48), 0, 1,  1, 32'h48,  1, 1, 32'h40,  d(32'h40),  1);
    tv[41] = mk(0, 32'h200, 0, 0,         0, 0,  0, 32'h48,  0, 0, 32'h0,   0,          1);
    tv[42] = mk(0, 32'h200, 0, 0,         0, 0,  0, 32'h48,  0, 0, 0,       0,          0);

    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset rom_req",  32'(rom_req), 0);
    chk("reset rom_addr", rom_addr, 0);
    chk("reset stallreq", 32'(stallreq_if), 0);
    chk("reset id_valid", 32'(id_valid), 0);
    chk("reset id_pc",    id_pc, 0);
    chk("reset id_inst",  id_inst, 0);
    @(negedge clk) rst = 1'b1;

    // Reset asserted mid-WAIT, then a late ack right after release
    @(negedge clk) drive(1, 32'h80, 0, 0, 0, 0);
    @(negedge clk) drive(0, 32'h80, 0, 0, 0, 0);
    #1;
    chk("wait rom_req",  32'(rom_req), 1);
    chk("wait rom_addr", rom_addr, 32'h80);
    rst = 1'b0;
    #1;
    chk("midreset rom_req",  32'(rom_req), 0);
    chk("midreset rom_addr", rom_addr, 0);
    chk("midreset stallreq", 32'(stallreq_if), 0);
    chk("midreset id_valid", 32'(id_valid), 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) drive(0, 32'h80, 1, 32'h1234_5678, 0, 0);
    @(negedge clk) drive(0, 32'h80, 0, 0, 0, 0);
    #1;
    chk("lateack rom_req",  32'(rom_req), 0);
    chk("lateack id_valid", 32'(id_valid), 0);
    @(negedge clk);
    #1;
    chk("lateack id_valid2", 32'(id_valid), 0);
    chk("lateack id_inst",   id_inst, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].en, tv[i].pc, tv[i].ack, tv[i].data, tv[i].st1, tv[i].fl);
      #1;
      chk($sformatf("row%0d rom_req", i),  32'(rom_req), 32'(tv[i].e_req));
      chk($sformatf("row%0d rom_addr", i), rom_addr, tv[i].e_addr);
      chk($sformatf("row%0d stallreq", i), 32'(stallreq_if), 32'(tv[i].e_sr));
      chk($sformatf("row%0d id_valid", i), 32'(id_valid), 32'(tv[i].e_val));
      chk($sformatf("row%0d id_inst", i),  id_inst, tv[i].e_inst);
      if (tv[i].cpc) chk($sformatf("row%0d id_pc", i), id_pc, tv[i].e_pc);
    end

`ifdef IFQ_PERF_CNT_EN
    // Fresh reset, then 5 stalled cycles (issue + 4 WAIT) and 2 flush pulses
    @(negedge clk) begin drive(0, 0, 0, 0, 0, 0); rst = 1'b0; end
    @(negedge clk) rst = 1'b1;
    #1;
    chk("perf reset stall", perf_stall_cnt, 0);
    chk("perf reset flush", perf_flush_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) drive(1, 32'h300, 0, 0, 0, 0);
    end
    @(negedge clk) drive(0, 32'h300, 0, 0, 0, 1);
    @(negedge clk) drive(0, 32'h300, 0, 0, 0, 0);
    @(negedge clk) drive(0, 32'h300, 0, 0, 0, 1);
    @(negedge clk) drive(0, 32'h300, 0, 0, 0, 0);
    #1;
    chk("perf stall cnt", perf_stall_cnt, 5);
    chk("perf flush cnt", perf_flush_cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
